// File: rtl/mips_cpu_pkg.sv
// Shared CPU types and constants; the memory arbiter additions live here.
package mips_cpu_pkg;

    typedef logic [31:0] im_addr_t;

    localparam int unsigned MEM_LAT        = 1;
    localparam int unsigned ARB_STARVE_MAX = 4;

    typedef enum logic {
        IDLE,
        READ_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating wait counter for the fetch port; o_force_if overrides data priority.
module arb_starve_cnt
    import mips_cpu_pkg::*;
#(
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_if_req,
    input  logic i_if_gnt,
    output logic o_force_if
);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_if_req || i_if_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != 4'(STARVE_MAX)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_force_if = (r_cnt == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority; a starvation guard forces fetch after STARVE_MAX lost cycles.
module mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = $bits(im_addr_t),
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LAT        = MEM_LAT,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_ce,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("mem_arbiter: LAT must be in 1..4");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("mem_arbiter: STARVE_MAX must be in 1..15");
    end

    arb_state_t        r_state, w_state_nxt;
    arb_owner_t        r_owner, w_owner_nxt;
    logic [2:0]        r_lat_cnt, w_lat_cnt_nxt;
    logic              w_force_if;
    logic              w_rd_done;
    logic              w_can_grant;
    logic              w_if_win;
    logic              w_dm_win;
    logic              r_mem_ce;
    logic [3:0]        r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .i_clk      (cpu_clk_50M),
        .i_rst_n    (cpu_rst_n),
        .i_if_req   (if_req),
        .i_if_gnt   (w_if_win),
        .o_force_if (w_force_if)
    );

    // The last READ_WAIT cycle doubles as a grant opportunity, so reads pipeline.
    assign w_rd_done   = (r_state == READ_WAIT) && (r_lat_cnt == 3'(LAT));
    assign w_can_grant = cpu_rst_n && ((r_state == IDLE) || w_rd_done);

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            r_state   <= IDLE;
            r_owner   <= OWN_NONE;
            r_lat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_lat_cnt_nxt = r_lat_cnt;
        w_if_win      = 1'b0;
        w_dm_win      = 1'b0;

        if (w_can_grant) begin
            w_if_win = if_req && (!dm_req || w_force_if);
            w_dm_win = dm_req && !(if_req && w_force_if);
        end

        case (r_state)
            IDLE: begin
                w_owner_nxt   = OWN_NONE;
                w_lat_cnt_nxt = '0;
            end
            READ_WAIT: begin
                if (w_rd_done) begin
                    w_state_nxt   = IDLE;
                    w_owner_nxt   = OWN_NONE;
                    w_lat_cnt_nxt = '0;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase

        if (w_if_win || (w_dm_win && (dm_we == 4'b0000))) begin
            w_state_nxt   = READ_WAIT;
            w_owner_nxt   = w_if_win ? OWN_IF : OWN_DM;
            w_lat_cnt_nxt = '0;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            r_mem_ce    <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_ce <= w_if_win || w_dm_win;
            if (w_dm_win) begin
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (w_if_win) begin
                r_mem_we    <= '0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end else begin
                r_mem_we    <= '0;
            end
        end
    end

    assign if_gnt    = w_if_win;
    assign dm_gnt    = w_dm_win;
    assign if_rvalid = cpu_rst_n && w_rd_done && (r_owner == OWN_IF);
    assign dm_rvalid = cpu_rst_n && w_rd_done && (r_owner == OWN_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign mem_ce    = r_mem_ce;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=1 instance and a LAT=3 instance on shared stimulus.
module tb_mem_arbiter;

    logic        cpu_clk_50M;
    logic        cpu_rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;

    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_ce;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    logic        if_gnt_3, if_rvalid_3, dm_gnt_3, dm_rvalid_3, mem_ce_3;
    logic [31:0] if_rdata_3, dm_rdata_3, mem_addr_3, mem_wdata_3;
    logic [3:0]  mem_we_3;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .STARVE_MAX(4)) u_dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3), .STARVE_MAX(4)) u_dut3 (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
        .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_3), .dm_rvalid(dm_rvalid_3), .dm_rdata(dm_rdata_3),
        .mem_ce(mem_ce_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata)
    );

    initial begin
        cpu_clk_50M = 1'b0;
        forever #5 cpu_clk_50M = ~cpu_clk_50M;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = '0;
        dm_addr  = '0;
        dm_wdata = '0;
    endtask

    task automatic idle_cycles(input int n);
        drive_idle();
        repeat (n) @(negedge cpu_clk_50M);
    endtask

    task automatic test_reset();
        drive_idle();
        mem_rdata = '0;
        cpu_rst_n = 1'b0;
        repeat (2) @(negedge cpu_clk_50M);
        if_req = 1'b1;
        dm_req = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt: got gnt/rvalid=%b want 0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid});
        end
        n_checks++;
        if ({mem_ce, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd: got ce=%b we=%h addr=%h wdata=%h want all 0", mem_ce, mem_we, mem_addr, mem_wdata);
        end
        @(negedge cpu_clk_50M);
        drive_idle();
        cpu_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk_50M);
            #1;
            n_checks++;
            if ({mem_ce, mem_we, mem_addr, mem_wdata, if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs[%0d]: got ce=%b we=%h addr=%h gnt=%b%b rv=%b%b want all 0",
                         i, mem_ce, mem_we, mem_addr, if_gnt, dm_gnt, if_rvalid, dm_rvalid);
            end
        end
    endtask

    task automatic test_fetch();
        @(negedge cpu_clk_50M);
        if_req = 1'b1; if_addr = 32'hBFC0_0000; mem_rdata = 32'h2408_0001;
        #1;
        n_checks++;
        if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_gnt: got if_gnt=%b dm_gnt=%b want 1 0", if_gnt, dm_gnt);
        end
        @(negedge cpu_clk_50M);
        if_req = 1'b0;
        #1;
        n_checks++;
        if (mem_ce !== 1'b1 || mem_addr !== 32'hBFC0_0000 || mem_we !== 4'h0) begin
            n_fail++;
            $display("FAIL fetch_cmd: got ce=%b addr=%h we=%h want 1 bfc00000 0", mem_ce, mem_addr, mem_we);
        end
        n_checks++;
        if (if_rvalid !== 1'b0 || if_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_early_rvalid: got rvalid=%b gnt=%b want 0 0", if_rvalid, if_gnt);
        end
        @(negedge cpu_clk_50M);
        #1;
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h2408_0001 || dm_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_rdata: got rvalid=%b rdata=%h dm_rvalid=%b want 1 24080001 0", if_rvalid, if_rdata, dm_rvalid);
        end
        n_checks++;
        if (mem_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_ce_drop: got ce=%b want 0", mem_ce);
        end
    endtask

    task automatic test_both_req();
        @(negedge cpu_clk_50M);
        if_req = 1'b1; if_addr = 32'h0000_0100;
        dm_req = 1'b1; dm_we = 4'h0; dm_addr = 32'h8000_0010;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL both_first: got dm_gnt=%b if_gnt=%b want 1 0", dm_gnt, if_gnt);
        end
        @(negedge cpu_clk_50M);
        dm_req = 1'b0;
        #1;
        n_checks++;
        if (mem_ce !== 1'b1 || mem_addr !== 32'h8000_0010 || if_gnt !== 1'b0 || dm_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL both_dm_cmd: got ce=%b addr=%h if_gnt=%b dm_rvalid=%b want 1 80000010 0 0",
                     mem_ce, mem_addr, if_gnt, dm_rvalid);
        end
        @(negedge cpu_clk_50M);
        #1;
        n_checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF || if_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL both_dm_rdata: got rvalid=%b rdata=%h if_rvalid=%b want 1 deadbeef 0", dm_rvalid, dm_rdata, if_rvalid);
        end
        n_checks++;
        if (if_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL both_if_gnt: got if_gnt=%b want 1", if_gnt);
        end
        @(negedge cpu_clk_50M);
        if_req = 1'b0; mem_rdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (mem_ce !== 1'b1 || mem_addr !== 32'h0000_0100 || dm_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL both_if_cmd: got ce=%b addr=%h dm_rvalid=%b want 1 00000100 0", mem_ce, mem_addr, dm_rvalid);
        end
        @(negedge cpu_clk_50M);
        #1;
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234_5678 || dm_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL both_if_rdata: got rvalid=%b rdata=%h dm_rvalid=%b want 1 12345678 0", if_rvalid, if_rdata, dm_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic exp_dm, exp_if;
        for (int i = 0; i < 5; i++) begin
            @(negedge cpu_clk_50M);
            if_req = 1'b1; if_addr = 32'h0000_0200;
            dm_req = 1'b1; dm_we = 4'hF;
            dm_addr = 32'h0000_1000 + 32'(4 * i); dm_wdata = 32'(i);
            mem_rdata = 32'h0BAD_F00D;
            #1;
            exp_dm = (i < 4);
            exp_if = (i == 4);
            n_checks++;
            if (dm_gnt !== exp_dm || if_gnt !== exp_if) begin
                n_fail++;
                $display("FAIL starve_grant[%0d]: got dm_gnt=%b if_gnt=%b want %b %b", i, dm_gnt, if_gnt, exp_dm, exp_if);
            end
        end
        @(negedge cpu_clk_50M);
        if_req = 1'b0;
        #1;
        n_checks++;
        if (mem_ce !== 1'b1 || mem_addr !== 32'h0000_0200 || mem_we !== 4'h0 || dm_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_if_cmd: got ce=%b addr=%h we=%h dm_gnt=%b want 1 00000200 0 0", mem_ce, mem_addr, mem_we, dm_gnt);
        end
        n_checks++;
        if (u_dut.u_starve.r_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL starve_cnt_clear: got %0d want 0", u_dut.u_starve.r_cnt);
        end
        @(negedge cpu_clk_50M);
        #1;
        n_checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BAD_F00D || dm_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_if_rdata: got rvalid=%b rdata=%h dm_gnt=%b want 1 0badf00d 1", if_rvalid, if_rdata, dm_gnt);
        end
        @(negedge cpu_clk_50M);
        dm_req = 1'b0;
        #1;
        n_checks++;
        if (mem_ce !== 1'b1 || mem_addr !== 32'h0000_1010 || mem_we !== 4'hF || mem_wdata !== 32'd4) begin
            n_fail++;
            $display("FAIL starve_dm_resume: got ce=%b addr=%h we=%h wdata=%h want 1 00001010 f 00000004",
                     mem_ce, mem_addr, mem_we, mem_wdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr, exp_wdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge cpu_clk_50M);
            if (i < 3) begin
                dm_req = 1'b1; dm_we = 4'hF;
                dm_addr = 32'(4 * i); dm_wdata = 32'h1111_1111 * 32'(i + 1);
            end else begin
                drive_idle();
            end
            #1;
            if (i < 3) begin
                n_checks++;
                if (dm_gnt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gnt[%0d]: got %b want 1", i, dm_gnt);
                end
            end
            if (i >= 1 && i <= 3) begin
                exp_addr  = 32'(4 * (i - 1));
                exp_wdata = 32'h1111_1111 * 32'(i);
                n_checks++;
                if (mem_ce !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_we !== 4'hF) begin
                    n_fail++;
                    $display("FAIL b2b_cmd[%0d]: got ce=%b addr=%h wdata=%h we=%h want 1 %h %h f",
                             i, mem_ce, mem_addr, mem_wdata, mem_we, exp_addr, exp_wdata);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (mem_ce !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ce_end: got %b want 0", mem_ce);
                end
            end
            n_checks++;
            if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_no_rvalid[%0d]: got dm=%b if=%b want 0 0", i, dm_rvalid, if_rvalid);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic exp_rv;
        drive_idle();
        cpu_rst_n = 1'b0;
        repeat (2) @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk_50M);
        if_req = 1'b1; if_addr = 32'h0000_0300; mem_rdata = 32'hA5A5_0300;
        #1;
        n_checks++;
        if (if_gnt_3 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst3_gnt: got %b want 1", if_gnt_3);
        end
        @(negedge cpu_clk_50M);
        if_req = 1'b0;
        #1;
        n_checks++;
        if (mem_ce_3 !== 1'b1 || mem_addr_3 !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL rst3_cmd: got ce=%b addr=%h want 1 00000300", mem_ce_3, mem_addr_3);
        end
        // Cycles C+1..C+3: reset lands at the end of C+2, so the C+3 rvalid must never appear.
        for (int i = 1; i <= 3; i++) begin
            @(negedge cpu_clk_50M);
            if (i == 2) cpu_rst_n = 1'b0;
            #1;
            n_checks++;
            if (if_rvalid_3 !== 1'b0 || dm_rvalid_3 !== 1'b0) begin
                n_fail++;
                $display("FAIL rst3_dropped[%0d]: got if_rv=%b dm_rv=%b want 0 0", i, if_rvalid_3, dm_rvalid_3);
            end
        end
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0400; mem_rdata = 32'h0400_CAFE;
        #1;
        n_checks++;
        if (if_gnt_3 !== 1'b1 || if_rvalid_3 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst3_regrant: got gnt=%b rvalid=%b want 1 0", if_gnt_3, if_rvalid_3);
        end
        @(negedge cpu_clk_50M);
        if_req = 1'b0;
        #1;
        n_checks++;
        if (mem_ce_3 !== 1'b1 || mem_addr_3 !== 32'h0000_0400 || if_gnt_3 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst3_new_cmd: got ce=%b addr=%h gnt=%b want 1 00000400 0", mem_ce_3, mem_addr_3, if_gnt_3);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge cpu_clk_50M);
            #1;
            exp_rv = (i == 3);
            n_checks++;
            if (if_rvalid_3 !== exp_rv) begin
                n_fail++;
                $display("FAIL rst3_lat3[%0d]: got rvalid=%b want %b", i, if_rvalid_3, exp_rv);
            end
            if (exp_rv) begin
                n_checks++;
                if (if_rdata_3 !== 32'h0400_CAFE) begin
                    n_fail++;
                    $display("FAIL rst3_rdata: got %h want 0400cafe", if_rdata_3);
                end
            end
        end
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        mem_rdata = '0;
        drive_idle();
        test_reset();
        test_fetch();
        idle_cycles(2);
        test_both_req();
        idle_cycles(2);
        test_starvation();
        idle_cycles(3);
        test_back_to_back();
        idle_cycles(2);
        test_reset_mid_read();
        idle_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
